// File: rtl/fetch_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fetch_stage: LC-3b instruction fetch with one-entry output register, |
// | skid buffer under backpressure and redirect with in-flight drop.     |
// | Revision: 1.0                                                        |
// +-----------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_ir,
  output logic [15:0] out_pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_drop_addr, w_drop_addr_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [15:0] r_out_ir, w_out_ir_nxt;
  logic [15:0] r_out_pc, w_out_pc_nxt;
  logic [15:0] r_skid_ir, w_skid_ir_nxt;
  logic [15:0] r_skid_pc, w_skid_pc_nxt;

  logic [15:0] w_pc_inc;
  logic [15:0] w_redirect_pc;
  logic        w_out_free;
  logic        w_unused;

  assign w_pc_inc      = r_pc + 16'd2;
  assign w_redirect_pc = {redirect_pc[15:1], 1'b0};
  assign w_out_free    = !r_out_valid || out_ready;
  assign w_unused      = redirect_pc[0];

  // The skid register is occupied exactly while the FSM sits in HOLD.
  assign imem_read    = !rst && (r_state != S_HOLD);
  assign imem_address = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign out_valid    = r_out_valid;
  assign out_ir       = r_out_ir;
  assign out_pc       = r_out_pc;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_addr_nxt = r_drop_addr;
    w_out_valid_nxt = r_out_valid;
    w_out_ir_nxt    = r_out_ir;
    w_out_pc_nxt    = r_out_pc;
    w_skid_ir_nxt   = r_skid_ir;
    w_skid_pc_nxt   = r_skid_pc;

    if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end

    if (redirect_valid) begin
      w_pc_nxt        = w_redirect_pc;
      w_out_valid_nxt = 1'b0;
      case (r_state)
        S_FETCH: begin
          // An outstanding request cannot be aborted; remember it so its response can be dropped.
          if (!imem_resp) begin
            w_drop_addr_nxt = r_pc;
            w_state_nxt     = S_DROP;
          end
        end
        S_HOLD:  w_state_nxt = S_FETCH;
        default: w_state_nxt = S_DROP;
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_resp) begin
            w_pc_nxt = w_pc_inc;
            if (w_out_free) begin
              w_out_ir_nxt    = imem_rdata;
              w_out_pc_nxt    = w_pc_inc;
              w_out_valid_nxt = 1'b1;
            end else begin
              w_skid_ir_nxt = imem_rdata;
              w_skid_pc_nxt = w_pc_inc;
              w_state_nxt   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            w_out_ir_nxt    = r_skid_ir;
            w_out_pc_nxt    = r_skid_pc;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = S_FETCH;
          end
        end
        default: begin
          if (imem_resp) begin
            w_state_nxt = S_FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= {RESET_PC[15:1], 1'b0};
      r_drop_addr <= 16'h0000;
      r_out_valid <= 1'b0;
      r_out_ir    <= 16'h0000;
      r_out_pc    <= 16'h0000;
      r_skid_ir   <= 16'h0000;
      r_skid_pc   <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop_addr <= w_drop_addr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_ir    <= w_out_ir_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_skid_ir   <= w_skid_ir_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
    end
  end

endmodule
`default_nettype wire
